rgb_led_arbiter: RTL and testbench
==================================

Name: rgb_led_arbiter

Overview:
Shares the single on-chip RGB LED between NUM_REQ status sources. Requesters post a colour and an optional blink request. The arbiter grants one requester at a time using fixed priority with a minimum hold time. It drives the three PWM inputs of the RGB driver primitive, and sits between the status logic and the SB_RGBA_DRV instance, clocked from the 48 MHz internal oscillator.

Parameters:
NUM_REQ, 4, number of requesters (2..8); index 0 has the highest priority.
TICK_DIV, 48000, clk cycles per 1 ms tick.
HOLD_MS, 250, minimum ticks a grant is held before a higher-priority requester may preempt it.
BLINK_MS, 500, blink half-period in ticks.

Ports:
clk  in  1  48 MHz oscillator clock.
rst_n  in  1  asynchronous, active-low reset.
req  in  NUM_REQ  level request; bit i belongs to requester i.
color  in  3*NUM_REQ  per-requester colour {blue,green,red} in bits [3i+2:3i].
blink  in  NUM_REQ  requester i wants its colour blinked.
grant  out  NUM_REQ  one-hot grant, or all zero.
busy  out  1  high while any grant is active.
led_red_pwm  out  1  to driver RGB0PWM.
led_green_pwm  out  1  to driver RGB1PWM.
led_blue_pwm  out  1  to driver RGB2PWM.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0: grant=0, busy=0, all LED outputs=0, and every counter is cleared. Asserting rst_n mid-operation forces these values immediately.
- Tick generator: tick_cnt counts 0..TICK_DIV-1 and wraps. It runs freely from reset release. A one-cycle tick pulse occurs when tick_cnt==TICK_DIV-1.
- The FSM has two states, IDLE and GRANT.
- IDLE:
  - Outputs are 0.
  - If req!=0, the winner is the lowest set index. On the next edge: state=GRANT, grant=onehot(winner), hold_cnt=0, blink_cnt=0, phase=1.
- GRANT, with granted index g:
  - On each tick, hold_cnt increments and saturates at HOLD_MS.
  - On each tick, blink_cnt counts 0..BLINK_MS-1. At the wrap, phase toggles.
  - If req[g]=0: re-arbitrate over the current req on the same edge. The new winner is granted (counters and phase reset as above), or the FSM returns to IDLE if req==0. The hold time does not apply to a voluntary release.
  - If req[g]=1, a lower index j<g has req[j]=1, and hold_cnt==HOLD_MS: preempt to the lowest such j (counters and phase reset).
  - Higher-index requests never preempt.
- Latency: the grant, busy and LED outputs are registered and update together one cycle after req is sampled. A change of color[g] appears on the LEDs one cycle later.
- LED outputs in GRANT: {b,g,r} = color[g] & {3{phase | ~blink[g]}}. If blink[g] is toggled while granted, it takes effect on the next cycle; phase keeps running.
- Colour 3'b000 while granted: the LEDs are off but the grant is held.
- busy = (state==GRANT). Grant is never multi-hot and never changes more than once per cycle.
- Simultaneous release of g and a new request: arbitration uses the req value sampled on that edge only.

Optional Feature:
Macro: RGB_PWM_DIM_EN.
- When defined: adds input duty (4 bits) and a free-running 4-bit pwm_cnt, reset to 0. Each LED output is additionally ANDed with (pwm_cnt < duty). duty=0 gives all LEDs off; duty=15 gives on for 15 of every 16 cycles. duty is sampled every cycle.
- When undefined: no duty port and no pwm_cnt; the outputs are the static gated colour.

Test Plan:
1. Reset with req=0 -> grant=0, busy=0, LEDs=000. Assert rst_n low mid-GRANT -> outputs 0 in the same cycle.
2. req=4'b0100, color[2]=3'b011, blink=0 -> grant=4'b0100 and red=green=1 one cycle later. Drop req -> IDLE and LEDs 000 one cycle later.
3. Requester 3 granted; requester 0 requests at tick 10 -> no change until hold_cnt=250, then grant=4'b0001 on the next edge.
4. Requester 0 granted; requester 2 requests -> grant stays 4'b0001 indefinitely. Requester 0 releases -> grant=4'b0100 next cycle with no hold wait.
5. blink[1]=1, color=3'b100 (use TICK_DIV=4, BLINK_MS=3 for simulation) -> blue on for 12 cycles, off for 12, repeating; the first on-phase starts at the grant.
6. RGB_PWM_DIM_EN defined, duty=4, colour white -> each output high 4 of every 16 cycles. duty=0 -> constant 0.

Source files
------------

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: shares the RGB LED between NUM_REQ sources (fixed priority, min hold).
// Build option RGB_PWM_DIM_EN adds a 4-bit duty input for PWM dimming.
module rgb_led_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int TICK_DIV = 48000,
    parameter int HOLD_MS  = 250,
    parameter int BLINK_MS = 500
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [3*NUM_REQ-1:0] color,
    input  logic [NUM_REQ-1:0]   blink,
`ifdef RGB_PWM_DIM_EN
    input  logic [3:0]           duty,
`endif
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 led_red_pwm,
    output logic                 led_green_pwm,
    output logic                 led_blue_pwm
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_MS + 1);
    localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MS);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]         state, st_n;
    logic [IW-1:0]      gidx, g_n, win;
    logic               any;
    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [HW-1:0]      hold_cnt, hold_n;
    logic [BW-1:0]      blink_cnt, bc_n;
    logic               phase, ph_n;
    logic               load;
    logic [NUM_REQ-1:0] grant_n;
    logic [2:0]         col_sel, led_n, led_q;
    logic               dim_on;

    assign tick = (tick_cnt == TICK_LAST);

    // Lowest set index wins; this also finds the lowest preempting requester.
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win = IW'(i);
                any = 1'b1;
            end
        end
    end

    always_comb begin
        st_n   = state;
        g_n    = gidx;
        hold_n = hold_cnt;
        bc_n   = blink_cnt;
        ph_n   = phase;
        load   = 1'b0;
        if (state == IDLE) begin
            load = any;
        end else if (!req[gidx]) begin
            load = any;
            if (!any) st_n = IDLE;
        end else if (win < gidx && hold_cnt == HOLD_LAST) begin
            load = 1'b1;
        end else if (tick) begin
            if (hold_cnt != HOLD_LAST) hold_n = hold_cnt + HW'(1);
            if (blink_cnt == BLINK_LAST) begin
                bc_n = '0;
                ph_n = ~phase;
            end else begin
                bc_n = blink_cnt + BW'(1);
            end
        end
        if (load) begin
            st_n   = GRANT;
            g_n    = win;
            hold_n = '0;
            bc_n   = '0;
            ph_n   = 1'b1;
        end
    end

    // LEDs are computed from next-state values so they move with the grant.
    always_comb begin
        grant_n = '0;
        led_n   = '0;
        col_sel = color[3*int'(g_n) +: 3];
        if (st_n == GRANT) begin
            grant_n[g_n] = 1'b1;
            led_n = col_sel & {3{ph_n | ~blink[g_n]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gidx      <= '0;
            tick_cnt  <= '0;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            grant     <= '0;
            led_q     <= '0;
        end else begin
            state     <= st_n;
            gidx      <= g_n;
            tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
            hold_cnt  <= hold_n;
            blink_cnt <= bc_n;
            phase     <= ph_n;
            grant     <= grant_n;
            led_q     <= led_n;
        end
    end

`ifdef RGB_PWM_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign dim_on = (pwm_cnt < duty);
`else
    assign dim_on = 1'b1;
`endif

    assign busy = (state == GRANT);
    assign {led_blue_pwm, led_green_pwm, led_red_pwm} = led_q & {3{dim_on}};

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter: directed vector table plus hand sequences for hold, blink and reset.
// Small timing parameters: TICK_DIV=4, HOLD_MS=5, BLINK_MS=3.
module tb_rgb_led_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [11:0]  color = '0;
    logic [N-1:0] blink = '0;
    logic [N-1:0] grant;
    logic         busy;
    logic         led_r, led_g, led_b;
    logic [2:0]   led;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign led = {led_b, led_g, led_r};

`ifdef RGB_PWM_DIM_EN
    logic [3:0] duty = 4'd15;
    logic [3:0] pc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else        pc <= pc + 4'd1;
    end

    function automatic logic [2:0] dimx(input logic [2:0] v);
        return v & {3{pc < duty}};
    endfunction
`else
    function automatic logic [2:0] dimx(input logic [2:0] v);
        return v;
    endfunction
`endif

    rgb_led_arbiter #(
        .NUM_REQ (N),
        .TICK_DIV(4),
        .HOLD_MS (5),
        .BLINK_MS(3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .color        (color),
        .blink        (blink),
`ifdef RGB_PWM_DIM_EN
        .duty         (duty),
`endif
        .grant        (grant),
        .busy         (busy),
        .led_red_pwm  (led_r),
        .led_green_pwm(led_g),
        .led_blue_pwm (led_b)
    );

    typedef struct {
        logic [N-1:0] req;
        logic [11:0]  color;
        logic [N-1:0] blink;
        logic [N-1:0] grant;
        logic         busy;
        logic [2:0]   led;
    } vec_t;

    vec_t tbl[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        blink = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cnt;
        int hits_r, hits_g, hits_b;
        logic steady;
        localparam logic [11:0] C   = 12'b100_011_010_001;
        localparam logic [11:0] C11 = 12'b100_011_111_001;
        localparam logic [11:0] C10 = 12'b100_011_000_001;

        tbl[0]  = '{4'b0000, C,   4'b0000, 4'b0000, 1'b0, 3'b000};
        tbl[1]  = '{4'b0100, C,   4'b0000, 4'b0100, 1'b1, 3'b011};
        tbl[2]  = '{4'b0000, C,   4'b0000, 4'b0000, 1'b0, 3'b000};
        tbl[3]  = '{4'b1000, C,   4'b0000, 4'b1000, 1'b1, 3'b100};
        tbl[4]  = '{4'b1100, C,   4'b0000, 4'b1000, 1'b1, 3'b100};
        tbl[5]  = '{4'b0100, C,   4'b0000, 4'b0100, 1'b1, 3'b011};
        tbl[6]  = '{4'b0110, C,   4'b0000, 4'b0100, 1'b1, 3'b011};
        tbl[7]  = '{4'b0011, C,   4'b0000, 4'b0001, 1'b1, 3'b001};
        tbl[8]  = '{4'b1111, C,   4'b0000, 4'b0001, 1'b1, 3'b001};
        tbl[9]  = '{4'b1110, C,   4'b0000, 4'b0010, 1'b1, 3'b010};
        tbl[10] = '{4'b1110, C11, 4'b0000, 4'b0010, 1'b1, 3'b111};
        tbl[11] = '{4'b1110, C10, 4'b0000, 4'b0010, 1'b1, 3'b000};
        tbl[12] = '{4'b1110, C11, 4'b0010, 4'b0010, 1'b1, 3'b111};
        tbl[13] = '{4'b0000, C11, 4'b0010, 4'b0000, 1'b0, 3'b000};

        // reset state while rst_n is held low
        step();
        check("reset_grant", grant, 4'b0000);
        check("reset_busy", busy, 1'b0);
        check("reset_led", led, 3'b000);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            req   = tbl[i].req;
            color = tbl[i].color;
            blink = tbl[i].blink;
            step();
            check($sformatf("vec%0d_grant", i), grant, tbl[i].grant);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            check($sformatf("vec%0d_led", i), led, dimx(tbl[i].led));
        end

        // preemption only after the hold time has elapsed
        do_reset();
        color = C;
        req = 4'b1000;
        step();
        check("pre_grant3", grant, 4'b1000);
        req = 4'b1001;
        n = 0;
        do begin
            step();
            n++;
        end while (grant == 4'b1000 && n < 40);
        check("pre_grant0", grant, 4'b0001);
        check("pre_wait_in_range", (n >= 18 && n <= 21), 1'b1);

        // higher index never preempts; voluntary release needs no hold
        req = 4'b0101;
        steady = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (grant != 4'b0001) steady = 1'b0;
        end
        check("no_low_preempt", steady, 1'b1);
        req = 4'b0100;
        step();
        check("release_grant2", grant, 4'b0100);
        check("release_led", led, dimx(3'b011));

        // asynchronous reset mid-grant forces outputs immediately
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", grant, 4'b0000);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_led", led, 3'b000);

`ifndef RGB_PWM_DIM_EN
        // blink: on from the grant, then 12 off / 12 on
        do_reset();
        color = 12'b000_000_100_000;
        blink = 4'b0010;
        req   = 4'b0010;
        step();
        check("blink_first_on", led, 3'b100);
        n = 0;
        do begin
            step();
            n++;
        end while (led_b && n < 30);
        check("blink_first_len", (n >= 9 && n <= 12), 1'b1);
        cnt = 1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (led_b) break;
            cnt++;
        end
        check("blink_off_len", cnt, 12);
        cnt = 1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (!led_b) break;
            cnt++;
        end
        check("blink_on_len", cnt, 12);
`else
        // dimming: duty 4 of 16, then duty 0
        do_reset();
        color = 12'b000_000_000_111;
        req   = 4'b0001;
        duty  = 4'd4;
        step();
        hits_r = 0;
        hits_g = 0;
        hits_b = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            hits_r += int'(led_r);
            hits_g += int'(led_g);
            hits_b += int'(led_b);
        end
        check("dim4_red", hits_r, 8);
        check("dim4_green", hits_g, 8);
        check("dim4_blue", hits_b, 8);
        duty = 4'd0;
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (led != 3'b000) cnt++;
        end
        check("dim0_off", cnt, 0);
        check("dim0_busy", busy, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
